// File: rtl/duart_sfr.sv
// Debug UART APB register block: TXD/CR/SR/ETUC registers, transmit-start strobe,
// and a busy flag that is cleared by a resynchronised done toggle from the serial clock domain.
module duart_sfr #(
  parameter logic [15:0] INITETU = 16'd32,
  parameter int          AW      = 12
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [31:0]   pwdata,
  output logic [31:0]   prdata,
  output logic          pready,
  output logic          pslverr,
  output logic [7:0]    txdata,
  output logic          txen,
  output logic [15:0]   etu,
  output logic          txstart,
  output logic          txbusy,
  input  logic          done_tgl
);

  localparam logic [AW-1:0] ADDR_TXD  = AW'(32'h0000_0000);
  localparam logic [AW-1:0] ADDR_CR   = AW'(32'h0000_0004);
  localparam logic [AW-1:0] ADDR_SR   = AW'(32'h0000_0008);
  localparam logic [AW-1:0] ADDR_ETUC = AW'(32'h0000_000C);

  logic        apbwr_s, apbrd_s;
  logic        sel_txd_s, sel_cr_s, sel_sr_s, sel_etuc_s;
  logic        done_pulse_s;
  logic        unused_pwdata_s;

  logic [7:0]  txdata_q, txdata_d;
  logic        txen_q, txen_d;
  logic [15:0] etu_q, etu_d;
  logic        txstart_q, txstart_d;
  logic        txbusy_q, txbusy_d;
  logic        s1_q, s2_q, s3_q;

  assign apbwr_s    = psel & penable & pwrite;
  assign apbrd_s    = psel & penable & ~pwrite;
  assign sel_txd_s  = (paddr == ADDR_TXD);
  assign sel_cr_s   = (paddr == ADDR_CR);
  assign sel_sr_s   = (paddr == ADDR_SR);
  assign sel_etuc_s = (paddr == ADDR_ETUC);

  assign done_pulse_s    = s2_q ^ s3_q;
  assign unused_pwdata_s = ^pwdata[31:16];

  // Register writes, start strobe and busy set/clear (set has priority over clear)
  always_comb begin
    txdata_d  = txdata_q;
    txen_d    = txen_q;
    etu_d     = etu_q;
    txbusy_d  = txbusy_q;
    txstart_d = apbwr_s & txen_q & sel_txd_s & ~txbusy_q;
    if (apbwr_s && sel_txd_s) begin
      txdata_d = pwdata[7:0];
    end else begin
      txdata_d = txdata_q;
    end
    if (apbwr_s && sel_cr_s) begin
      txen_d = pwdata[0];
    end else begin
      txen_d = txen_q;
    end
    if (apbwr_s && sel_etuc_s) begin
      etu_d = pwdata[15:0];
    end else begin
      etu_d = etu_q;
    end
    if (txstart_q) begin
      txbusy_d = 1'b1;
    end else if (done_pulse_s) begin
      txbusy_d = 1'b0;
    end else begin
      txbusy_d = txbusy_q;
    end
  end

  // State registers, including the three-flop done toggle synchroniser
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      txdata_q  <= 8'h00;
      txen_q    <= 1'b1;
      etu_q     <= INITETU;
      txstart_q <= 1'b0;
      txbusy_q  <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
    end else begin
      txdata_q  <= txdata_d;
      txen_q    <= txen_d;
      etu_q     <= etu_d;
      txstart_q <= txstart_d;
      txbusy_q  <= txbusy_d;
      s1_q      <= done_tgl;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
    end
  end

  assign prdata = ({32{apbrd_s & sel_txd_s}}  & {24'h00_0000, txdata_q})
                | ({32{apbrd_s & sel_cr_s}}   & {31'h0000_0000, txen_q})
                | ({32{apbrd_s & sel_sr_s}}   & {31'h0000_0000, txbusy_q})
                | ({32{apbrd_s & sel_etuc_s}} & {16'h0000, etu_q});

  assign pready  = 1'b1;
  assign pslverr = 1'b0;
  assign txdata  = txdata_q;
  assign txen    = txen_q;
  assign etu     = etu_q;
  assign txstart = txstart_q;
  assign txbusy  = txbusy_q;

endmodule

// File: tb/tb_duart_sfr.sv
// Directed self-checking bench for duart_sfr: register map, start strobe, busy tracking,
// done resynchronisation, back-to-back writes and asynchronous reset.
module tb_duart_sfr;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = 12'h000;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  txdata;
  logic        txen;
  logic [15:0] etu;
  logic        txstart, txbusy;
  logic        done_tgl = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  duart_sfr #(.INITETU(16'd32), .AW(12)) dut (
    .clk(clk), .resetn(resetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .txdata(txdata), .txen(txen), .etu(etu), .txstart(txstart), .txbusy(txbusy),
    .done_tgl(done_tgl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end 1 ns after a rising edge.
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    #1 d = prdata;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic toggle_and_wait(input string tag);
    int cyc;
    cyc = 0;
    done_tgl = ~done_tgl;
    while (txbusy && cyc < 8) begin
      step();
      cyc++;
    end
    check({tag, "_busy_clr"}, {31'h0, txbusy}, 32'h0);
    check({tag, "_clr_lat_le4"}, {31'h0, (cyc <= 4)}, 32'h1);
  endtask

  logic [31:0] rd;

  initial begin
    #12 resetn = 1'b1;
    step();

    check("rst_prdata_idle", prdata, 32'h0);
    check("rst_pready", {31'h0, pready}, 32'h1);
    check("rst_pslverr", {31'h0, pslverr}, 32'h0);
    check("rst_txstart", {31'h0, txstart}, 32'h0);
    apb_read(12'h000, rd); check("rst_rd_txd", rd, 32'h0);
    apb_read(12'h004, rd); check("rst_rd_cr", rd, 32'h1);
    apb_read(12'h008, rd); check("rst_rd_sr", rd, 32'h0);
    apb_read(12'h00C, rd); check("rst_rd_etuc", rd, 32'h20);

    apb_write(12'h00C, 32'hFFFF_1234);
    check("etu_out", {16'h0, etu}, 32'h1234);
    apb_read(12'h00C, rd); check("etu_rd", rd, 32'h0000_1234);
    apb_write(12'h010, 32'hFFFF_FFFF);
    check("unmapped_etu", {16'h0, etu}, 32'h1234);
    check("unmapped_txd", {24'h0, txdata}, 32'h0);
    check("unmapped_txen", {31'h0, txen}, 32'h1);
    apb_read(12'h010, rd); check("unmapped_rd", rd, 32'h0);
    apb_write(12'h008, 32'h0000_0001);
    check("sr_write_ignored", {31'h0, txbusy}, 32'h0);

    apb_write(12'h000, 32'hFFFF_FF41);
    check("tx1_data", {24'h0, txdata}, 32'h41);
    check("tx1_start", {31'h0, txstart}, 32'h1);
    check("tx1_busy_early", {31'h0, txbusy}, 32'h0);
    step();
    check("tx1_start_one", {31'h0, txstart}, 32'h0);
    check("tx1_busy", {31'h0, txbusy}, 32'h1);
    apb_read(12'h008, rd); check("tx1_sr", rd, 32'h1);

    apb_write(12'h000, 32'h0000_0042);
    check("busy_wr_data", {24'h0, txdata}, 32'h42);
    check("busy_wr_nostart", {31'h0, txstart}, 32'h0);
    toggle_and_wait("done1");
    apb_read(12'h008, rd); check("done1_sr", rd, 32'h0);

    apb_write(12'h004, 32'h0000_0000);
    check("txen_off", {31'h0, txen}, 32'h0);
    apb_read(12'h004, rd); check("cr_rd_off", rd, 32'h0);
    apb_write(12'h000, 32'h0000_0055);
    check("dis_nostart", {31'h0, txstart}, 32'h0);
    check("dis_data", {24'h0, txdata}, 32'h55);
    step();
    check("dis_nobusy", {31'h0, txbusy}, 32'h0);

    apb_write(12'h004, 32'hFFFF_FFFF);
    check("txen_on", {31'h0, txen}, 32'h1);
    apb_write(12'h000, 32'h0000_0055);
    check("en_start", {31'h0, txstart}, 32'h1);
    step();
    check("en_busy", {31'h0, txbusy}, 32'h1);
    toggle_and_wait("done2");

    // Two access phases in consecutive cycles: the second still sees txbusy low.
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 12'h000; pwdata = 32'h0000_0061;
    step();
    penable = 1'b1;
    step();
    check("b2b_start1", {31'h0, txstart}, 32'h1);
    check("b2b_busy1", {31'h0, txbusy}, 32'h0);
    pwdata = 32'h0000_0062;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check("b2b_start2", {31'h0, txstart}, 32'h1);
    check("b2b_data2", {24'h0, txdata}, 32'h62);
    check("b2b_busy2", {31'h0, txbusy}, 32'h1);
    step();
    check("b2b_start_end", {31'h0, txstart}, 32'h0);
    check("b2b_busy3", {31'h0, txbusy}, 32'h1);

    // Asynchronous reset while busy, sampled before any further clock edge.
    apb_write(12'h004, 32'h0);
    #1 resetn = 1'b0;
    #1;
    check("arst_txbusy", {31'h0, txbusy}, 32'h0);
    check("arst_txstart", {31'h0, txstart}, 32'h0);
    check("arst_txdata", {24'h0, txdata}, 32'h0);
    check("arst_txen", {31'h0, txen}, 32'h1);
    check("arst_etu", {16'h0, etu}, 32'h20);
    check("arst_prdata", prdata, 32'h0);
    #10 resetn = 1'b1;
    step();
    check("post_rst_busy", {31'h0, txbusy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/duart_sfr.md
# duart_sfr

APB-attached register block for the debug UART. It holds the transmit-data, enable and ETU (bit-period) control registers and a read-only busy status bit. It generates a one-cycle transmit-start strobe and tracks transmitter busy state. Completion events arrive from the serial-clock domain as a toggle and are resynchronised in this block.

## Interface
Parameters:
- `INITETU`, default 32: reset value of the ETU register (16 bit).
- `AW`, default 12: APB address width.

Ports:
- `clk`  in  1: APB/register clock; all logic uses the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `psel`  in  1: APB select.
- `penable`  in  1: APB access phase.
- `pwrite`  in  1: 1 = write, 0 = read.
- `paddr`  in  AW: byte address.
- `pwdata`  in  32: write data.
- `prdata`  out  32: read data.
- `pready`  out  1: tied to 1 (zero wait states).
- `pslverr`  out  1: tied to 0.
- `txdata`  out  8: TXD register.
- `txen`  out  1: CR bit 0.
- `etu`  out  16: ETUC register.
- `txstart`  out  1: one-cycle start strobe.
- `txbusy`  out  1: busy flag.
- `done_tgl`  in  1: asynchronous toggle; each edge (rise or fall) means one transmission finished.

## Operation
- `apbwr` = `psel & penable & pwrite`.
- `apbrd` = `psel & penable & ~pwrite`.
- Address decode is an exact compare of the full `paddr`.
- Register map:
  - 0x00 TXD: R/W, bits [7:0], reset 0.
  - 0x04 CR: R/W, bit 0 = `txen`, reset 1.
  - 0x08 SR: RO, bit 0 = `txbusy`.
  - 0x0C ETUC: R/W, bits [15:0], reset `INITETU`.
- Writes store `pwdata[DW-1:0]` (DW = register width); upper bits are ignored. Writes to SR or unmapped addresses have no effect.
- `prdata` is the OR of all register read contributions.
  - Each register drives its value, zero-extended to 32 bits, only while `apbrd` is high and `paddr` matches its address; otherwise it drives 0.
  - An unmapped read or an idle bus gives 0.
- Start strobe:
  - An internal registered strobe is set to `apbwr & txen & (paddr==0) & ~txbusy`, all terms evaluated in the access-phase cycle; it drives the `txstart` output.
  - A TXD write while `txen`=0 or `txbusy`=1 still updates TXD but produces no strobe.
- Done synchroniser: `done_tgl` passes through two flops (`s1`, `s2`) and then a third flop `s3`; `done_pulse` = `s2 ^ s3`. All three flops reset to 0.
- Busy flag:
  - On the cycle `txstart` is 1, `txbusy` is set.
  - Else, on a cycle `done_pulse` is 1, `txbusy` is cleared.
  - Otherwise `txbusy` holds.
  - If both occur in the same cycle, set wins.

## Timing
- Reset values: `txdata`=0, `txen`=1, `etu`=`INITETU`, `txstart`=0, `txbusy`=0, `prdata`=0. `pready`=1 and `pslverr`=0 at all times.
- Register outputs update on the rising edge that ends the access phase and are visible in the next cycle.
- `prdata` is combinational during the access phase, with 0 wait states.
- `txstart` is high exactly one cycle, the cycle after the TXD write access phase.
- `txbusy` is high from the cycle after the `txstart` pulse until clear.
- `done_tgl` edge to `done_pulse`: 2–3 `clk` cycles (metastability window). `txbusy` falls one cycle after `done_pulse`.
- Back-to-back TXD writes:
  - The second write is still accepted for TXD storage.
  - Its access phase comes one cycle after the first, while `txstart` is high and `txbusy` is still 0, so it sees `~txbusy` and raises the strobe again.
  - Software therefore must poll SR between bytes.
- Reset asserted mid-operation clears everything immediately, asynchronously; pending toggle history is lost.

## Test plan
- Reset → read 0x00=0, 0x04=1, 0x08=0, 0x0C=0x20; `pready`=1, `pslverr`=0.
- Write 0x0C=0xFFFF_1234 → `etu`=0x1234 and read 0x0C returns 0x0000_1234. Write 0x10 → no change; read 0x10=0.
- `txen`=1, write 0x00=0x41 → `txdata`=0x41, a single-cycle `txstart` the next cycle, SR reads 1 afterwards.
- While busy, write 0x00=0x42 → `txdata`=0x42, no `txstart`. Toggle `done_tgl` → `txbusy` clears within 4 cycles and SR reads 0.
- Write 0x04=0, then 0x00=0x55 → no `txstart`, `txbusy` stays 0. Write 0x04=1, then 0x00=0x55 → `txstart` is generated.
- Assert `resetn` low while `txbusy`=1 → all outputs return to reset values without waiting for a clock.
